// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer:
//   - FunSel[3:0] operation codes of the 32-bit ALU
//   - lower bound of the single-bit shift/rotate range
//   - condition-code encodings
//   - bit positions inside the ALU FlagsOut vector ({Z,C,N,O})
//   - sequencer state enum
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  // ALU operation codes (FunSel[3:0]); FunSel[4] selects 32-bit vs 16-bit.
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADDC = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_LSL  = 4'b1011;
  localparam logic [3:0] OP_LSR  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1101;
  localparam logic [3:0] OP_CSL  = 4'b1110;
  localparam logic [3:0] OP_CSR  = 4'b1111;

  // Ops at or above this code are single-bit shifts/rotates that honour a
  // pass count; everything below runs exactly one pass.
  localparam logic [3:0] OP_SHIFT_LO = 4'b1011;

  // Condition codes.
  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CS = 3'd3;
  localparam logic [2:0] COND_CC = 3'd4;
  localparam logic [2:0] COND_MI = 3'd5;
  localparam logic [2:0] COND_VS = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  // Bit positions inside FlagsOut.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return op >= OP_SHIFT_LO;
  endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// -----------------------------------------------------------------------------
// alu_cond_eval
// Combinational condition-code check against the ALU's registered flags.
// Ports:
//   cond_i  [2:0] condition code (AL, EQ, NE, CS, CC, MI, VS, NV)
//   flags_i [3:0] ALU flags {Z,C,N,O}
//   pass_o        1 when the condition holds and the op should issue
// -----------------------------------------------------------------------------
module alu_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pass_o = 1'b0;
    case (cond_i)
      COND_AL: pass_o = 1'b1;
      COND_EQ: pass_o = flags_i[FLAG_Z];
      COND_NE: pass_o = ~flags_i[FLAG_Z];
      COND_CS: pass_o = flags_i[FLAG_C];
      COND_CC: pass_o = ~flags_i[FLAG_C];
      COND_MI: pass_o = flags_i[FLAG_N];
      COND_VS: pass_o = flags_i[FLAG_O];
      default: pass_o = 1'b0;  // NV never issues
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Control-side driver for the 32-bit ALU. Accepts one request over a
// valid/ready handshake, issues one or more ALU passes (shift-by-N is built
// from repeated single-bit shifts with the result fed back on the A operand),
// captures ALUOut into Result and presents a response.
//
// Configuration macro: ALU_SEQ_COND_EN
//   defined   - ReqCond is evaluated against FlagsIn at accept; a failing
//               condition skips straight to the response with RespSkipped=1.
//   undefined - every request executes, RespSkipped is always 0.
//
// Ports:
//   Clock, Reset            clock, synchronous active-high reset
//   ReqValid/ReqReady       request handshake (ReqReady high only in IDLE)
//   ReqOp, ReqWide          FunSel[3:0] and FunSel[4] of the request
//   ReqCount                shift/rotate passes minus one
//   ReqCond, ReqSetFlags    condition code, drive WF on issued passes
//   FunSel, WF, ASel        ALU controls (ASel=1 feeds Result back on A)
//   FlagsIn                 ALU FlagsOut {Z,C,N,O}
//   ALUIn                   ALU ALUOut
//   Result                  captured result register
//   RespValid/RespReady     response handshake
//   RespSkipped             condition failed, no pass issued
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [3:0]  ReqOp,
  input  logic        ReqWide,
  input  logic [4:0]  ReqCount,
  input  logic [2:0]  ReqCond,
  input  logic        ReqSetFlags,
  output logic [4:0]  FunSel,
  output logic        WF,
  output logic        ASel,
  input  logic [3:0]  FlagsIn,
  input  logic [31:0] ALUIn,
  output logic [31:0] Result,
  output logic        RespValid,
  output logic        RespSkipped,
  input  logic        RespReady
);

  state_e      state_q;
  logic [4:0]  remain_q;      // passes still to run after the current one
  logic [4:0]  funsel_q;
  logic        wf_q;
  logic        asel_q;
  logic [31:0] result_q;
  logic        resp_valid_q;
  logic        resp_skipped_q;

  logic        cond_pass;
  logic [4:0]  pass_cnt;

`ifdef ALU_SEQ_COND_EN
  alu_cond_eval u_cond_eval (
    .cond_i  (ReqCond),
    .flags_i (FlagsIn),
    .pass_o  (cond_pass)
  );
`else
  assign cond_pass = 1'b1;
  logic unused_cond;
  assign unused_cond = ^{ReqCond, FlagsIn};
`endif

  // Non-shift ops ignore the count and run a single pass. A 5-bit remaining
  // counter holds 31 directly, so 32 passes never wrap.
  assign pass_cnt = is_shift_op(ReqOp) ? ReqCount : 5'd0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      remain_q       <= '0;
      funsel_q       <= '0;
      wf_q           <= 1'b0;
      asel_q         <= 1'b0;
      result_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_skipped_q <= 1'b0;
    end else begin
      // NOTE: state is written with non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          if (ReqValid) begin
            if (cond_pass) begin
              // ALU controls are registered here so they are valid for the
              // whole first EXEC cycle.
              state_q  <= ST_EXEC;
              funsel_q <= {ReqWide, ReqOp};
              wf_q     <= ReqSetFlags;
              asel_q   <= 1'b0;
              remain_q <= pass_cnt;
            end else begin
              state_q        <= ST_RESP;
              resp_valid_q   <= 1'b1;
              resp_skipped_q <= 1'b1;
            end
          end
        end

        ST_EXEC: begin
          result_q <= ALUIn;
          if (remain_q == 5'd0) begin
            state_q        <= ST_RESP;
            funsel_q       <= '0;
            wf_q           <= 1'b0;
            asel_q         <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_skipped_q <= 1'b0;
          end else begin
            remain_q <= remain_q - 5'd1;
            asel_q   <= 1'b1;  // later passes operate on the previous result
          end
        end

        ST_RESP: begin
          if (RespReady) begin
            state_q        <= ST_IDLE;
            resp_valid_q   <= 1'b0;
            resp_skipped_q <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ReqReady    = (state_q == ST_IDLE);
  assign FunSel      = funsel_q;
  assign WF          = wf_q;
  assign ASel        = asel_q;
  assign Result      = result_q;
  assign RespValid   = resp_valid_q;
  assign RespSkipped = resp_skipped_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer with a behavioural ALU model
// (ADD, LSL, LSR, 16-bit sign extension, A-operand feedback mux). Expected
// responses are queued when a request is driven and popped when the DUT
// presents RespValid. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [3:0]  ReqOp;
  logic        ReqWide;
  logic [4:0]  ReqCount;
  logic [2:0]  ReqCond;
  logic        ReqSetFlags;
  logic [4:0]  FunSel;
  logic        WF;
  logic        ASel;
  logic [3:0]  FlagsIn;
  logic [31:0] ALUIn;
  logic [31:0] Result;
  logic        RespValid;
  logic        RespSkipped;
  logic        RespReady;

  logic [31:0] ext_a, ext_b;
  logic [31:0] a_mux, alu_raw;

  typedef struct {
    logic [31:0] result;
    logic        skipped;
  } resp_t;

  resp_t       sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .Clock       (clk),
    .Reset       (Reset),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqOp       (ReqOp),
    .ReqWide     (ReqWide),
    .ReqCount    (ReqCount),
    .ReqCond     (ReqCond),
    .ReqSetFlags (ReqSetFlags),
    .FunSel      (FunSel),
    .WF          (WF),
    .ASel        (ASel),
    .FlagsIn     (FlagsIn),
    .ALUIn       (ALUIn),
    .Result      (Result),
    .RespValid   (RespValid),
    .RespSkipped (RespSkipped),
    .RespReady   (RespReady)
  );

  // Behavioural ALU: combinational output from FunSel and the A-mux.
  always_comb begin
    a_mux   = ASel ? Result : ext_a;
    alu_raw = a_mux;
    case (FunSel[3:0])
      OP_ADD:  alu_raw = a_mux + ext_b;
      OP_LSL:  alu_raw = a_mux << 1;
      OP_LSR:  alu_raw = a_mux >> 1;
      default: alu_raw = a_mux;
    endcase
    ALUIn = FunSel[4] ? alu_raw : {{16{alu_raw[15]}}, alu_raw[15:0]};
  end

  // Drives one request, checks every EXEC cycle, the latency, the response
  // contents, stability while RespReady is held low, and the return to IDLE.
  task automatic run_op(input logic [3:0] op, input logic wide,
                        input logic [4:0] cnt, input logic [2:0] cond,
                        input logic setf, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_skip, input int exp_passes,
                        input int hold, input string name);
    resp_t exp;
    int    n;
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: ReqReady=%b want 1", name, ReqReady);
    end
    ext_a = a; ext_b = b;
    ReqOp = op; ReqWide = wide; ReqCount = cnt; ReqCond = cond;
    ReqSetFlags = setf; ReqValid = 1'b1;
    sb.push_back('{result: exp_res, skipped: exp_skip});
    @(negedge clk);
    ReqValid = 1'b0;
    n = 0;
    while (RespValid !== 1'b1 && n < 40) begin
      n_checks++;
      if ({FunSel, WF, ASel, ReqReady} !== {wide, op, setf, (n != 0), 1'b0}) begin
        n_fail++;
        $display("FAIL %s exec%0d: FunSel=%b WF=%b ASel=%b ReqReady=%b want %b %b %b 0",
                 name, n, FunSel, WF, ASel, ReqReady, {wide, op}, setf, (n != 0));
      end
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== exp_passes || RespValid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: passes=%0d RespValid=%b want passes=%0d RespValid=1",
               name, n, RespValid, exp_passes);
    end
    exp = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      n_checks++;
      if ({RespValid, ReqReady, RespSkipped, FunSel, WF, ASel} !==
          {1'b1, 1'b0, exp.skipped, 5'b00000, 1'b0, 1'b0} || Result !== exp.result) begin
        n_fail++;
        $display("FAIL %s resp%0d: V=%b Rdy=%b Skip=%b FunSel=%b WF=%b ASel=%b Result=%h want V=1 Rdy=0 Skip=%b ctl=0 Result=%h",
                 name, h, RespValid, ReqReady, RespSkipped, FunSel, WF, ASel, Result,
                 exp.skipped, exp.result);
      end
      if (h == hold) RespReady = 1'b1;
      @(negedge clk);
    end
    RespReady = 1'b0;
    n_checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0 || Result !== exp.result) begin
      n_fail++;
      $display("FAIL %s idle_after: ReqReady=%b RespValid=%b Result=%h want 1 0 %h",
               name, ReqReady, RespValid, Result, exp.result);
    end
    last_res = exp.result;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ReqReady, RespValid, RespSkipped, WF, ASel, FunSel} !== 10'b1_0_0_0_0_00000 ||
        Result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: Rdy=%b V=%b Skip=%b WF=%b ASel=%b FunSel=%b Result=%h want 1 0 0 0 0 00000 0",
               ReqReady, RespValid, RespSkipped, WF, ASel, FunSel, Result);
    end
    Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_op(OP_ADD, 1'b1, 5'd0, COND_AL, 1'b1, 32'd5, 32'd7, 32'd12, 1'b0, 1, 0, "add_wide");
    // Count is ignored for non-shift ops; 16-bit mode sign-extends.
    run_op(OP_ADD, 1'b0, 5'd9, COND_AL, 1'b0, 32'd100, 32'd23, 32'd123, 1'b0, 1, 0, "add_cnt_ignored");
    run_op(OP_ADD, 1'b0, 5'd0, COND_AL, 1'b1, 32'h0000_7FFF, 32'd1, 32'hFFFF_8000, 1'b0, 1, 0, "add_narrow_sext");
  endtask

  task automatic test_shift();
    run_op(OP_LSR, 1'b1, 5'd3, COND_AL, 1'b1, 32'h80, 32'd0, 32'h08, 1'b0, 4, 0, "lsr4");
    run_op(OP_LSL, 1'b1, 5'd7, COND_AL, 1'b0, 32'h0000_0003, 32'd0, 32'h0000_0300, 1'b0, 8, 0, "lsl8");
  endtask

  task automatic test_max_count();
    // 32 passes shift out every bit; a wrapped count would leave bits set.
    run_op(OP_LSR, 1'b1, 5'd31, COND_AL, 1'b1, 32'h8000_0001, 32'd0, 32'd0, 1'b0, 32, 0, "lsr32");
  endtask

  task automatic test_cond();
`ifdef ALU_SEQ_COND_EN
    FlagsIn = 4'b0000;
    run_op(OP_ADD, 1'b1, 5'd0, COND_EQ, 1'b1, 32'd1, 32'd2, last_res, 1'b1, 0, 0, "eq_skip");
    run_op(OP_ADD, 1'b1, 5'd0, COND_NE, 1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1, 0, "ne_take");
    FlagsIn = 4'b1000;
    run_op(OP_ADD, 1'b1, 5'd0, COND_EQ, 1'b1, 32'd4, 32'd2, 32'd6, 1'b0, 1, 0, "eq_take");
    FlagsIn = 4'b1111;
    run_op(OP_ADD, 1'b1, 5'd0, COND_NV, 1'b1, 32'd9, 32'd9, last_res, 1'b1, 0, 0, "nv_skip");
    FlagsIn = 4'b0100;
    run_op(OP_ADD, 1'b1, 5'd0, COND_CC, 1'b1, 32'd9, 32'd9, last_res, 1'b1, 0, 0, "cc_skip");
`else
    FlagsIn = 4'b0000;
    run_op(OP_ADD, 1'b1, 5'd0, COND_EQ, 1'b1, 32'd1, 32'd2, 32'd3, 1'b0, 1, 0, "eq_ignored");
    run_op(OP_ADD, 1'b1, 5'd0, COND_NV, 1'b1, 32'd4, 32'd2, 32'd6, 1'b0, 1, 0, "nv_ignored");
`endif
    FlagsIn = 4'b0000;
  endtask

  task automatic test_resp_hold();
    run_op(OP_ADD, 1'b1, 5'd0, COND_AL, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1, 3, "hold3");
  endtask

  task automatic test_back_to_back();
    // Each run_op accepts in the cycle right after the previous handshake.
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h100 << i;
      run_op(OP_LSR, 1'b1, 5'(i), COND_AL, 1'b1, a, 32'd0, a >> (i + 1), 1'b0, i + 1, 0, "b2b");
    end
  endtask

  task automatic test_reset_mid_op();
    bit bad;
    ext_a = 32'hFFFF_0000; ext_b = 32'd0;
    ReqOp = OP_LSR; ReqWide = 1'b1; ReqCount = 5'd10; ReqCond = COND_AL;
    ReqSetFlags = 1'b1; ReqValid = 1'b1;
    @(negedge clk);
    ReqValid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (WF !== 1'b1 || ASel !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pass4: WF=%b ASel=%b want 1 1", WF, ASel);
    end
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    n_checks++;
    if ({ReqReady, RespValid, WF, ASel, FunSel} !== 9'b1_0_0_0_00000 || Result !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: Rdy=%b V=%b WF=%b ASel=%b FunSel=%b Result=%h want 1 0 0 0 00000 0",
               ReqReady, RespValid, WF, ASel, FunSel, Result);
    end
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (RespValid !== 1'b0 || WF !== 1'b0 || ReqReady !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL mid_after: activity after reset, want RespValid=0 WF=0 ReqReady=1");
    end
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; ReqOp = '0; ReqWide = 1'b0; ReqCount = '0;
    ReqCond = COND_AL; ReqSetFlags = 1'b0; FlagsIn = '0; RespReady = 1'b0;
    ext_a = '0; ext_b = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_shift();
    test_max_count();
    test_cond();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
